// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

   localparam int MAX_WIDTH = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Quotient reported for a zero divisor: all ones in the low w bits.
   function automatic logic [MAX_WIDTH-1:0] zero_div_quotient(input int w);
      return {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - w);
   endfunction

endpackage

// File: rtl/div_seq_if.sv
// Operand/result handshake bundle for div_seq; master is the producer/consumer side.
interface div_seq_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract D.
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   r,
   input  logic             q_msb,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   r_next,
   output logic             q_bit
);
   logic signed [WIDTH+1:0] trial;

   // Two guard bits keep the trial difference's sign bit separate from the remainder range.
   assign trial  = $signed({r, q_msb}) - $signed({2'b00, d});
   assign q_bit  = ~trial[WIDTH+1];
   assign r_next = q_bit ? trial[WIDTH:0] : {r[WIDTH-1:0], q_msb};
endmodule

// File: rtl/div_seq.sv
// Unsigned radix-2 restoring divider, one quotient bit per cycle, valid/ready on both sides.
module div_seq
   import div_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic     clk,
   input  logic     rst_n,
   div_seq_if.slave bus
);
   localparam logic [MAX_WIDTH-1:0] ZDQ_FULL = zero_div_quotient(WIDTH);
   localparam logic [WIDTH-1:0]     ZDQ      = ZDQ_FULL[WIDTH-1:0];
   localparam logic [CNT_W-1:0]     LAST     = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH:0]     r;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   d;
   logic [WIDTH:0]     r_next;
   logic               q_bit;
   logic [WIDTH-1:0]   q_next;
   logic               in_ready;
   logic               out_valid;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
   logic               div_by_zero;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r),
      .q_msb  (q[WIDTH-1]),
      .d      (d),
      .r_next (r_next),
      .q_bit  (q_bit)
   );

   assign q_next = {q[WIDTH-2:0], q_bit};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         r           <= '0;
         q           <= '0;
         d           <= '0;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  q        <= bus.dividend;
                  d        <= bus.divisor;
                  r        <= '0;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  // A zero divisor skips the iteration and reports immediately.
                  if (bus.divisor == '0) begin
                     state       <= DONE;
                     out_valid   <= 1'b1;
                     quotient    <= ZDQ;
                     remainder   <= bus.dividend;
                     div_by_zero <= 1'b1;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               r   <= r_next;
               q   <= q_next;
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  state       <= DONE;
                  out_valid   <= 1'b1;
                  quotient    <= q_next;
                  remainder   <= r_next[WIDTH-1:0];
                  div_by_zero <= 1'b0;
               end
            end
            DONE: begin
               // Results stay on the outputs after the handshake; only out_valid drops.
               if (bus.out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready    = in_ready;
   assign bus.out_valid   = out_valid;
   assign bus.quotient    = quotient;
   assign bus.remainder   = remainder;
   assign bus.div_by_zero = div_by_zero;
endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: directed WIDTH=8 scenarios plus a throttled WIDTH=32 random run.
module tb_div_seq;
   localparam int N_RAND = 1200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   typedef struct {
      logic [31:0] n;
      logic [31:0] d;
   } op_t;
   op_t sb[$];

   always #5 clk = ~clk;

   div_seq_if #(.WIDTH(8))  bus8 ();
   div_seq_if #(.WIDTH(32)) bus32 ();

   div_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
   div_seq #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one 8-bit operation to completion; lat is edges from accept to out_valid (-1 on timeout).
   task automatic do_op8(input logic [7:0] n, input logic [7:0] dv,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic z, output int lat);
      int guard = 0;
      while (bus8.in_ready !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      bus8.dividend  = n;
      bus8.divisor   = dv;
      bus8.in_valid  = 1'b1;
      bus8.out_ready = 1'b0;
      tick();
      bus8.in_valid = 1'b0;
      bus8.dividend = 8'($urandom);
      bus8.divisor  = 8'($urandom);
      lat = 0;
      while (bus8.out_valid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      if (guard >= 50 || lat >= 40) lat = -1;
      q = bus8.quotient;
      r = bus8.remainder;
      z = bus8.div_by_zero;
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus8.in_valid = 1'b0;  bus8.out_ready = 1'b0;  bus8.dividend = '0;  bus8.divisor = '0;
      bus32.in_valid = 1'b0; bus32.out_ready = 1'b0; bus32.dividend = '0; bus32.divisor = '0;
      rst_n = 1'b0;
      #12;
      vectors++;
      if (bus8.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus8.in_ready);
      end
      vectors++;
      if (bus8.out_valid !== 1'b0) begin
         miscompares++; $display("FAIL reset_out_valid: got %b want 0", bus8.out_valid);
      end
      vectors++;
      if (bus8.quotient !== 8'd0 || bus8.remainder !== 8'd0 || bus8.div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_results: got q=%0d r=%0d z=%b want 0 0 0",
                  bus8.quotient, bus8.remainder, bus8.div_by_zero);
      end
      vectors++;
      if (bus32.in_ready !== 1'b1 || bus32.out_valid !== 1'b0 || bus32.quotient !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_w32: got rdy=%b vld=%b q=%0d want 1 0 0",
                  bus32.in_ready, bus32.out_valid, bus32.quotient);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      vectors++;
      if (bus8.in_ready !== 1'b1) begin
         miscompares++; $display("FAIL basic_ready_before: got %b want 1", bus8.in_ready);
      end
      bus8.dividend = 8'd100; bus8.divisor = 8'd7; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      // Cycle k is the interval after edge k-1; in_ready low for cycles 1..9, out_valid from cycle 9.
      for (int k = 1; k <= 9; k++) begin
         vectors++;
         if (bus8.in_ready !== 1'b0 || bus8.out_valid !== (k == 9)) begin
            miscompares++;
            $display("FAIL basic_cycle%0d: got rdy=%b vld=%b want rdy=0 vld=%b",
                     k, bus8.in_ready, bus8.out_valid, (k == 9));
         end
         if (k < 9) tick();
      end
      vectors++;
      if (bus8.quotient !== 8'd14 || bus8.remainder !== 8'd2 || bus8.div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_result: got %0d r %0d z=%b want 14 r 2 z=0",
                  bus8.quotient, bus8.remainder, bus8.div_by_zero);
      end
      tick();
      bus8.out_ready = 1'b0;
      vectors++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_after_hs: got vld=%b rdy=%b want 0 1", bus8.out_valid, bus8.in_ready);
      end
   endtask

   task automatic test_sequence();
      logic [7:0] ns [3] = '{8'd255, 8'd5, 8'd200};
      logic [7:0] ds [3] = '{8'd1, 8'd9, 8'd200};
      logic [7:0] q, r;
      logic z;
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_op8(ns[i], ds[i], q, r, z, lat);
         vectors++;
         if (lat != 8 || q !== ns[i] / ds[i] || r !== ns[i] % ds[i] || z !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_%0d_%0d: got %0d r %0d z=%b lat=%0d want %0d r %0d z=0 lat=8",
                     ns[i], ds[i], q, r, z, lat, ns[i] / ds[i], ns[i] % ds[i]);
         end
         vectors++;
         if (bus8.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL seq_ready_%0d: got %b want 1", i, bus8.in_ready);
         end
      end
   endtask

   task automatic test_zero_div();
      logic [7:0] q, r;
      logic z;
      int lat;
      do_op8(8'h5A, 8'd0, q, r, z, lat);
      vectors++;
      if (lat != 0 || q !== 8'hFF || r !== 8'h5A || z !== 1'b1) begin
         miscompares++;
         $display("FAIL zero_div: got q=%h r=%h z=%b lat=%0d want ff 5a 1 lat=0", q, r, z, lat);
      end
      do_op8(8'd9, 8'd3, q, r, z, lat);
      vectors++;
      if (lat != 8 || q !== 8'd3 || r !== 8'd0 || z !== 1'b0) begin
         miscompares++;
         $display("FAIL after_zero_div: got %0d r %0d z=%b lat=%0d want 3 r 0 z=0 lat=8", q, r, z, lat);
      end
   endtask

   task automatic test_backpressure();
      int g = 0;
      bus8.dividend = 8'd100; bus8.divisor = 8'd7; bus8.in_valid = 1'b1; bus8.out_ready = 1'b0;
      tick();
      bus8.in_valid = 1'b0;
      while (bus8.out_valid !== 1'b1 && g < 40) begin
         tick();
         g++;
      end
      for (int k = 0; k < 20; k++) begin
         vectors++;
         if (bus8.out_valid !== 1'b1 || bus8.quotient !== 8'd14 || bus8.remainder !== 8'd2 ||
             bus8.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_hold%0d: got vld=%b q=%0d r=%0d rdy=%b want 1 14 2 0",
                     k, bus8.out_valid, bus8.quotient, bus8.remainder, bus8.in_ready);
         end
         tick();
      end
      bus8.out_ready = 1'b1;
      tick();
      bus8.out_ready = 1'b0;
      vectors++;
      if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", bus8.out_valid, bus8.in_ready);
      end
   endtask

   task automatic test_reset_midop();
      logic [7:0] q, r;
      logic z;
      int lat;
      int seen = 0;
      bus8.dividend = 8'd100; bus8.divisor = 8'd7; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      repeat (4) tick();
      #2;
      rst_n = 1'b0;
      #1;
      vectors++;
      if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.quotient !== 8'd0 ||
          bus8.remainder !== 8'd0 || bus8.div_by_zero !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_reset: got rdy=%b vld=%b q=%0d r=%0d z=%b want 1 0 0 0 0",
                  bus8.in_ready, bus8.out_valid, bus8.quotient, bus8.remainder, bus8.div_by_zero);
      end
      tick();
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus8.out_valid === 1'b1) seen++;
      end
      bus8.out_ready = 1'b0;
      vectors++;
      if (seen != 0) begin
         miscompares++; $display("FAIL midop_ghost: got %0d out_valid cycles want 0", seen);
      end
      do_op8(8'd50, 8'd6, q, r, z, lat);
      vectors++;
      if (lat != 8 || q !== 8'd8 || r !== 8'd2 || z !== 1'b0) begin
         miscompares++;
         $display("FAIL midop_fresh: got %0d r %0d z=%b lat=%0d want 8 r 2 z=0 lat=8", q, r, z, lat);
      end
   endtask

   task automatic test_random32();
      int got = 0;
      int stray = 0;
      fork
         begin : producer
            for (int i = 0; i < N_RAND; i++) begin
               logic [31:0] n, dv;
               logic acc;
               int g;
               int sel;
               n   = $urandom;
               sel = $urandom_range(0, 7);
               case (sel)
                  0:       dv = 32'd0;
                  1:       dv = 32'd1;
                  2:       dv = n;
                  3:       begin n = n & 32'hFFFF; dv = n + 32'd1 + $urandom_range(0, 1000); end
                  4:       dv = 32'($urandom_range(1, 255));
                  default: dv = $urandom;
               endcase
               repeat ($urandom_range(0, 2)) tick();
               bus32.dividend = n;
               bus32.divisor  = dv;
               bus32.in_valid = 1'b1;
               acc = 1'b0;
               g   = 0;
               while (!acc && g < 200) begin
                  acc = bus32.in_ready;
                  tick();
                  g++;
               end
               bus32.in_valid = 1'b0;
               if (acc) sb.push_back('{n: n, d: dv});
               else begin
                  vectors++; miscompares++;
                  $display("FAIL rand_accept_timeout: op %0d not accepted within 200 cycles", i);
               end
            end
         end
         begin : consumer
            int cyc = 0;
            while (got < N_RAND && cyc < 80000) begin
               logic hs;
               logic [31:0] cq, cr;
               logic cz;
               bus32.out_ready = ($urandom_range(0, 3) != 0);
               hs = bus32.out_valid && bus32.out_ready;
               cq = bus32.quotient;
               cr = bus32.remainder;
               cz = bus32.div_by_zero;
               tick();
               cyc++;
               if (hs) begin
                  got++;
                  vectors++;
                  if (sb.size() == 0) begin
                     miscompares++; $display("FAIL rand_dup: result q=%0d r=%0d with no pending op", cq, cr);
                  end else begin
                     op_t op;
                     logic [31:0] eq, er;
                     logic ez;
                     logic [63:0] recon;
                     op = sb.pop_front();
                     ez = (op.d == 32'd0);
                     eq = ez ? 32'hFFFF_FFFF : op.n / op.d;
                     er = ez ? op.n : op.n % op.d;
                     if (cq !== eq || cr !== er || cz !== ez) begin
                        miscompares++;
                        $display("FAIL rand_result %0d/%0d: got %0d r %0d z=%b want %0d r %0d z=%b",
                                 op.n, op.d, cq, cr, cz, eq, er, ez);
                     end
                     if (!ez) begin
                        vectors++;
                        recon = 64'(cq) * 64'(op.d) + 64'(cr);
                        if (recon !== 64'(op.n) || !(cr < op.d)) begin
                           miscompares++;
                           $display("FAIL rand_identity %0d/%0d: got q*d+r=%0d r=%0d want %0d and r<d",
                                    op.n, op.d, recon, cr, op.n);
                        end
                     end
                  end
               end
            end
            bus32.out_ready = 1'b0;
         end
      join
      bus32.out_ready = 1'b1;
      repeat (40) begin
         tick();
         if (bus32.out_valid === 1'b1) stray++;
      end
      bus32.out_ready = 1'b0;
      vectors++;
      if (got != N_RAND || sb.size() != 0 || stray != 0) begin
         miscompares++;
         $display("FAIL rand_count: got %0d results, %0d pending, %0d stray want %0d 0 0",
                  got, sb.size(), stray, N_RAND);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sequence();
      test_zero_div();
      test_backpressure();
      test_reset_midop();
      test_random32();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
